// File: rtl/mips_irq_ctrl.sv
// mips_irq_ctrl: external interrupt controller for the MIPS core.
// Latches rising edges of peripheral requests as pending, applies a
// software mask, and presents one prioritised request at a time on o_irq.
// The request is tracked through acknowledge (exception taken) and eret.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no request outstanding; waiting for an unmasked pending bit
// REQ      | o_irq asserted for o_irq_id; waiting for ack or withdrawal
// SERVICE  | handler running; new edges only accumulate until eret
module mips_irq_ctrl #(
  parameter int N_SRC = 8,
  parameter int ID_W  = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_SRC-1:0] i_src,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [1:0]       i_addr,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata,
  input  logic             i_ack,
  input  logic             i_eret,
  output logic             o_irq,
  output logic [ID_W-1:0]  o_irq_id
);

  // STATUS register exposes this encoding directly
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] A_PENDING = 2'd0;
  localparam logic [1:0] A_MASK    = 2'd1;
  localparam logic [1:0] A_ID      = 2'd2;
  localparam logic [1:0] A_STATUS  = 2'd3;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic             irq_q, irq_d;
  logic [ID_W-1:0]  id_q, id_d;

  logic [N_SRC-1:0] edge_det;
  logic [N_SRC-1:0] active;
  logic [N_SRC-1:0] wr_clr;
  logic [N_SRC-1:0] ack_clr;
  logic [ID_W-1:0]  win_id;
  logic             ack_taken;

  assign edge_det  = i_src & ~src_q;
  assign active    = pending_q & mask_q;
  assign ack_taken = i_ack && (state_q == S_REQ);

  // Priority encoder: lowest-numbered active source wins
  always_comb begin
    win_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) win_id = ID_W'(i);
    end
  end

  // Clear sources: software W1C on PENDING and acknowledge of the latched ID
  always_comb begin
    wr_clr  = '0;
    ack_clr = '0;
    if (i_we && (i_addr == A_PENDING)) wr_clr = i_wdata[N_SRC-1:0];
    for (int i = 0; i < N_SRC; i++) begin
      ack_clr[i] = ack_taken && (id_q == ID_W'(i));
    end
  end

  // Pending/mask next state; a new edge always beats a clear in the same cycle
  always_comb begin
    pending_d = (pending_q & ~(wr_clr | ack_clr)) | edge_det;
    mask_d    = mask_q;
    if (i_we && (i_addr == A_MASK)) mask_d = i_wdata[N_SRC-1:0];
  end

  // Request FSM: next state, registered irq and ID
  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    id_d    = id_q;
    unique case (state_q)
      S_IDLE: begin
        irq_d = 1'b0;
        if (|active) begin
          id_d    = win_id;
          irq_d   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        irq_d = 1'b1;
        if (i_ack) begin
          // ack wins over a simultaneous withdrawal
          irq_d   = 1'b0;
          state_d = S_SERVICE;
        end else if (!active[id_q]) begin
          irq_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_SERVICE: begin
        irq_d = 1'b0;
        if (i_eret) state_d = S_IDLE;
      end
      default: begin
        irq_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers, all cleared asynchronously so o_irq drops at once
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      irq_q     <= 1'b0;
      id_q      <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= i_src;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      irq_q     <= irq_d;
      id_q      <= id_d;
    end
  end

  // Read mux: zero-extended registers, zero when not reading
  always_comb begin
    o_rdata = '0;
    if (i_re) begin
      unique case (i_addr)
        A_PENDING: o_rdata[N_SRC-1:0] = pending_q;
        A_MASK:    o_rdata[N_SRC-1:0] = mask_q;
        A_ID: begin
          o_rdata[31]       = (state_q == S_REQ) || (state_q == S_SERVICE);
          o_rdata[ID_W-1:0] = id_q;
        end
        A_STATUS:  o_rdata[1:0] = state_q;
        default:   o_rdata = '0;
      endcase
    end
  end

  assign o_irq    = irq_q;
  assign o_irq_id = id_q;

endmodule

// File: tb/tb_mips_irq_ctrl.sv
// Self-checking bench for mips_irq_ctrl (N_SRC=8).
// Each vector row drives inputs at the falling edge; o_rdata is checked
// against the pre-edge state, o_irq/o_irq_id against the post-edge state.
module tb_mips_irq_ctrl;

  localparam int N = 8;
  localparam int W = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  src;
  logic          we, re, ack, eret;
  logic [1:0]    addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          irq;
  logic [W-1:0]  irq_id;

  int n_cmp = 0;
  int n_bad = 0;

  mips_irq_ctrl #(.N_SRC(N), .ID_W(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_src(src), .i_we(we), .i_re(re),
    .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata), .i_ack(ack),
    .i_eret(eret), .o_irq(irq), .o_irq_id(irq_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  src;
    logic        we;
    logic        re;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        ack;
    logic        eret;
    logic [31:0] exp_rd;
    logic        exp_irq;
    logic [2:0]  exp_id;
  } vec_t;

  typedef struct {
    int          row;
    logic [31:0] rd;
    logic        irq;
    logic [2:0]  id;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[44];

  function automatic vec_t mk(logic [7:0] s, logic w, logic r, logic [1:0] a,
                              logic [31:0] d, logic k, logic e,
                              logic [31:0] xr, logic xi, logic [2:0] xd);
    vec_t v;
    v.src = s; v.we = w; v.re = r; v.addr = a; v.wdata = d;
    v.ack = k; v.eret = e; v.exp_rd = xr; v.exp_irq = xi; v.exp_id = xd;
    return v;
  endfunction

  task automatic cmp(string name, int row, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic apply(int row, vec_t v);
    exp_t e;
    @(negedge clk);
    src = v.src; we = v.we; re = v.re; addr = v.addr; wdata = v.wdata;
    ack = v.ack; eret = v.eret;
    e.row = row; e.rd = v.exp_rd; e.irq = v.exp_irq; e.id = v.exp_id;
    sb.push_back(e);
    #1;
    cmp("rdata", row, rdata, sb[0].rd);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    cmp("irq", e.row, {31'd0, irq}, {31'd0, e.irq});
    cmp("irq_id", e.row, {29'd0, irq_id}, {29'd0, e.id});
  endtask

  initial begin
    //             src  we re addr wdata        ack eret exp_rd       irq id
    // basic flow on source 2
    tbl[0]  = mk(8'h00, 1, 1, 2'd1, 32'h04,       0, 0, 32'h0,        0, 0);
    tbl[1]  = mk(8'h04, 0, 1, 2'd0, 32'h0,        0, 0, 32'h0,        0, 0);
    tbl[2]  = mk(8'h04, 0, 1, 2'd0, 32'h0,        0, 0, 32'h04,       1, 2);
    tbl[3]  = mk(8'h00, 0, 1, 2'd2, 32'h0,        0, 0, 32'h80000002, 1, 2);
    tbl[4]  = mk(8'h00, 0, 1, 2'd3, 32'h0,        1, 0, 32'h1,        0, 2);
    tbl[5]  = mk(8'h00, 0, 1, 2'd0, 32'h0,        0, 0, 32'h0,        0, 2);
    tbl[6]  = mk(8'h00, 0, 1, 2'd3, 32'h0,        0, 1, 32'h2,        0, 2);
    tbl[7]  = mk(8'h00, 0, 1, 2'd3, 32'h0,        0, 0, 32'h0,        0, 2);
    tbl[8]  = mk(8'h00, 0, 1, 2'd2, 32'h0,        0, 0, 32'h2,        0, 2);
    // priority: sources 5 and 1 together
    tbl[9]  = mk(8'h00, 1, 1, 2'd1, 32'hFF,       0, 0, 32'h04,       0, 2);
    tbl[10] = mk(8'h22, 0, 1, 2'd0, 32'h0,        0, 0, 32'h0,        0, 2);
    tbl[11] = mk(8'h22, 0, 1, 2'd0, 32'h0,        0, 0, 32'h22,       1, 1);
    tbl[12] = mk(8'h00, 0, 1, 2'd2, 32'h0,        1, 0, 32'h80000001, 0, 1);
    tbl[13] = mk(8'h00, 0, 1, 2'd0, 32'h0,        0, 1, 32'h20,       0, 1);
    tbl[14] = mk(8'h00, 0, 1, 2'd3, 32'h0,        0, 0, 32'h0,        1, 5);
    tbl[15] = mk(8'h00, 0, 1, 2'd2, 32'h0,        1, 0, 32'h80000005, 0, 5);
    tbl[16] = mk(8'h00, 0, 1, 2'd0, 32'h0,        0, 1, 32'h0,        0, 5);
    // masking and withdrawal on source 3
    tbl[17] = mk(8'h00, 1, 1, 2'd1, 32'h0,        0, 0, 32'hFF,       0, 5);
    tbl[18] = mk(8'h08, 0, 1, 2'd1, 32'h0,        0, 0, 32'h0,        0, 5);
    tbl[19] = mk(8'h08, 0, 1, 2'd0, 32'h0,        0, 0, 32'h08,       0, 5);
    tbl[20] = mk(8'h00, 1, 1, 2'd1, 32'h08,       0, 0, 32'h0,        0, 5);
    tbl[21] = mk(8'h00, 0, 1, 2'd1, 32'h0,        0, 0, 32'h08,       1, 3);
    tbl[22] = mk(8'h00, 1, 1, 2'd0, 32'h08,       0, 0, 32'h08,       1, 3);
    tbl[23] = mk(8'h00, 0, 1, 2'd3, 32'h0,        0, 0, 32'h1,        0, 3);
    tbl[24] = mk(8'h00, 0, 1, 2'd3, 32'h0,        0, 0, 32'h0,        0, 3);
    tbl[25] = mk(8'h00, 0, 1, 2'd0, 32'h0,        0, 0, 32'h0,        0, 3);
    // set-wins race on source 4
    tbl[26] = mk(8'h00, 1, 1, 2'd1, 32'h10,       0, 0, 32'h08,       0, 3);
    tbl[27] = mk(8'h10, 0, 1, 2'd0, 32'h0,        0, 0, 32'h0,        0, 3);
    tbl[28] = mk(8'h10, 0, 1, 2'd0, 32'h0,        0, 0, 32'h10,       1, 4);
    tbl[29] = mk(8'h00, 0, 1, 2'd2, 32'h0,        0, 0, 32'h80000004, 1, 4);
    tbl[30] = mk(8'h10, 0, 1, 2'd0, 32'h0,        1, 0, 32'h10,       0, 4);
    tbl[31] = mk(8'h10, 0, 1, 2'd3, 32'h0,        0, 1, 32'h2,        0, 4);
    tbl[32] = mk(8'h10, 0, 1, 2'd0, 32'h0,        0, 0, 32'h10,       1, 4);
    // stray strobes
    tbl[33] = mk(8'h00, 0, 1, 2'd3, 32'h0,        0, 1, 32'h1,        1, 4);
    tbl[34] = mk(8'h00, 0, 1, 2'd3, 32'h0,        1, 0, 32'h1,        0, 4);
    tbl[35] = mk(8'h00, 0, 1, 2'd3, 32'h0,        0, 1, 32'h2,        0, 4);
    tbl[36] = mk(8'h00, 0, 1, 2'd3, 32'h0,        1, 0, 32'h0,        0, 4);
    tbl[37] = mk(8'h00, 0, 1, 2'd3, 32'h0,        0, 0, 32'h0,        0, 4);
    tbl[38] = mk(8'h00, 0, 1, 2'd0, 32'h0,        0, 0, 32'h0,        0, 4);
    // unimplemented mask bits, read-only registers, idle read port
    tbl[39] = mk(8'h00, 1, 1, 2'd1, 32'hFFFFFF10, 0, 0, 32'h10,       0, 4);
    tbl[40] = mk(8'h00, 0, 1, 2'd1, 32'h0,        0, 0, 32'h10,       0, 4);
    tbl[41] = mk(8'h00, 1, 1, 2'd3, 32'hFFFFFFFF, 0, 0, 32'h0,        0, 4);
    tbl[42] = mk(8'h00, 1, 1, 2'd2, 32'hFFFFFFFF, 0, 0, 32'h4,        0, 4);
    tbl[43] = mk(8'h00, 0, 0, 2'd1, 32'h0,        0, 0, 32'h0,        0, 4);

    rst = 1'b1; src = '0; we = 0; re = 0; ack = 0; eret = 0; addr = '0; wdata = '0;
    #2;
    cmp("rst_irq", -1, {31'd0, irq}, 32'd0);
    cmp("rst_id", -1, {29'd0, irq_id}, 32'd0);
    cmp("rst_rdata", -1, rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 44; i++) apply(i, tbl[i]);

    // reset while in REQ, with source 4 held high across the reset
    @(negedge clk);
    we = 0; re = 0; ack = 0; eret = 0; src = 8'h10;
    @(negedge clk);
    @(negedge clk);
    cmp("pre_rst_irq", 100, {31'd0, irq}, 32'd1);
    rst = 1'b1;
    #1;
    cmp("async_rst_irq", 100, {31'd0, irq}, 32'd0);
    cmp("async_rst_id", 100, {29'd0, irq_id}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    re = 1'b1;
    addr = 2'd3; #1; cmp("post_rst_status", 101, rdata, 32'd0);
    addr = 2'd1; #1; cmp("post_rst_mask", 101, rdata, 32'd0);
    addr = 2'd0; #1; cmp("post_rst_pending", 101, rdata, 32'd0);
    @(posedge clk);
    #1;
    cmp("held_src_edge", 102, rdata, 32'h10);
    cmp("held_src_irq", 102, {31'd0, irq}, 32'd0);
    @(negedge clk);
    re = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
